// File: rtl/lru_evict_pkg.sv
// Shared types and entry-layout helpers for the LRU victim drain block.
package lru_evict_pkg;

    localparam int unsigned LINE_WIDTH_DEF = 512;
    localparam int unsigned MEM_DATAW_DEF  = 64;
    localparam int unsigned ADDR_WIDTH_DEF = 26;
    localparam int unsigned DATAW_DEF      = 1 + ADDR_WIDTH_DEF + LINE_WIDTH_DEF;

    // Entry field offsets for the default geometry: {dirty, line_addr, line_data}
    localparam int unsigned DIRTY_BIT = DATAW_DEF - 1;
    localparam int unsigned ADDR_LSB  = LINE_WIDTH_DEF;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    // Same offsets for an arbitrary geometry
    function automatic int unsigned dirty_bit_of(input int unsigned line_w, input int unsigned addr_w);
        return line_w + addr_w;
    endfunction

    function automatic int unsigned addr_lsb_of(input int unsigned line_w);
        return line_w;
    endfunction

endpackage

// File: rtl/lru_evict_beat_mux.sv
// Selects the MEM_DATAW-wide slice of a cache line addressed by the beat index.
module lru_evict_beat_mux #(
    parameter int unsigned LINE_WIDTH = 512,
    parameter int unsigned MEM_DATAW  = 64,
    parameter int unsigned BEATW_I    = 3
) (
    input  logic [LINE_WIDTH-1:0] line,
    input  logic [BEATW_I-1:0]    beat_idx,
    output logic [MEM_DATAW-1:0]  beat_data
);

    localparam int unsigned BEATS = LINE_WIDTH / MEM_DATAW;

    always_comb begin
        beat_data = '0;
        for (int unsigned i = 0; i < BEATS; i++) begin
            if (beat_idx == BEATW_I'(i)) begin
                beat_data = line[i*MEM_DATAW +: MEM_DATAW];
            end
        end
    end

endmodule

// File: rtl/lru_evict_drain.sv
// Drains the LRU victim queue: drops clean lines, serializes dirty lines into memory write beats.
// Optional performance counters are enabled with `define LRU_EVICT_PERF_EN.
module lru_evict_drain
    import lru_evict_pkg::*;
#(
    parameter int unsigned LINE_WIDTH = LINE_WIDTH_DEF,
    parameter int unsigned MEM_DATAW  = MEM_DATAW_DEF,
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
    localparam int unsigned DATAW     = 1 + ADDR_WIDTH + LINE_WIDTH,
    localparam int unsigned BEATS     = LINE_WIDTH / MEM_DATAW,
    localparam int unsigned BEATW     = $clog2(BEATS),
    localparam int unsigned BEATW_I   = (BEATW == 0) ? 1 : BEATW
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        flush,
    output logic                        flush_done,
    input  logic                        q_empty,
    input  logic                        q_alm_full,
    input  logic [DATAW-1:0]            q_data,
    output logic                        q_pop,
    output logic                        mem_req_valid,
    input  logic                        mem_req_ready,
    output logic [ADDR_WIDTH+BEATW-1:0] mem_req_addr,
    output logic [MEM_DATAW-1:0]        mem_req_data,
    output logic                        mem_req_last,
`ifdef LRU_EVICT_PERF_EN
    output logic [31:0]                 perf_dirty_evicts,
    output logic [31:0]                 perf_clean_evicts,
    output logic [31:0]                 perf_stall_cycles,
`endif
    output logic                        busy
);

    localparam int unsigned        DIRTY_POS = dirty_bit_of(LINE_WIDTH, ADDR_WIDTH);
    localparam int unsigned        ADDR_POS  = addr_lsb_of(LINE_WIDTH);
    localparam logic [BEATW_I-1:0] LAST_BEAT = BEATW_I'(BEATS - 1);

    state_e                state, state_nxt;
    logic [BEATW_I-1:0]    beat_idx, beat_nxt;
    logic                  flush_active, flush_active_nxt;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [LINE_WIDTH-1:0] line_r;
    logic [MEM_DATAW-1:0]  beat_data;
    logic                  pop;
    logic                  drained;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            beat_idx     <= '0;
            flush_active <= 1'b0;
        end else begin
            state        <= state_nxt;
            beat_idx     <= beat_nxt;
            flush_active <= flush_active_nxt;
        end
    end

    // Line holding register; contents are only meaningful while in SEND
    always_ff @(posedge clk) begin
        if (pop) begin
            addr_r <= q_data[ADDR_POS +: ADDR_WIDTH];
            line_r <= q_data[LINE_WIDTH-1:0];
        end
    end

    always_comb begin
        state_nxt        = state;
        beat_nxt         = beat_idx;
        flush_active_nxt = flush_active;
        pop              = 1'b0;
        mem_req_valid    = 1'b0;
        mem_req_last     = 1'b0;
        flush_done       = 1'b0;
        drained          = 1'b0;

        case (state)
            IDLE: begin
                pop = reset && !q_empty && (q_alm_full || flush_active);
                if (pop && q_data[DIRTY_POS]) begin
                    state_nxt = SEND;
                    beat_nxt  = '0;
                end
            end
            SEND: begin
                mem_req_valid = 1'b1;
                mem_req_last  = (beat_idx == LAST_BEAT);
                if (mem_req_ready) begin
                    if (mem_req_last) begin
                        state_nxt = IDLE;
                        beat_nxt  = '0;
                    end else begin
                        beat_nxt = beat_idx + BEATW_I'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        // A flush request arriving while one is in progress is absorbed
        drained    = flush_active && (state == IDLE) && q_empty && !pop;
        flush_done = drained;
        if (!flush_active) begin
            flush_active_nxt = flush;
        end else if (drained) begin
            flush_active_nxt = 1'b0;
        end
    end

    lru_evict_beat_mux #(
        .LINE_WIDTH (LINE_WIDTH),
        .MEM_DATAW  (MEM_DATAW),
        .BEATW_I    (BEATW_I)
    ) u_beat_mux (
        .line      (line_r),
        .beat_idx  (beat_idx),
        .beat_data (beat_data)
    );

    generate
        if (BEATW == 0) begin : g_single_beat
            assign mem_req_addr = mem_req_valid ? addr_r : '0;
        end else begin : g_multi_beat
            assign mem_req_addr = mem_req_valid ? {addr_r, beat_idx} : '0;
        end
    endgenerate

    assign mem_req_data = mem_req_valid ? beat_data : '0;
    assign q_pop        = pop;
    assign busy         = (state != IDLE) || flush_active;

`ifdef LRU_EVICT_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_dirty_evicts <= '0;
            perf_clean_evicts <= '0;
            perf_stall_cycles <= '0;
        end else begin
            if (pop && q_data[DIRTY_POS]) begin
                perf_dirty_evicts <= perf_dirty_evicts + 32'd1;
            end
            if (pop && !q_data[DIRTY_POS]) begin
                perf_clean_evicts <= perf_clean_evicts + 32'd1;
            end
            if (mem_req_valid && !mem_req_ready) begin
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            end
        end
    end
`endif

    a_no_pop_when_empty: assert property (@(posedge clk) disable iff (!reset) !(pop && q_empty))
        else $error("q_pop asserted while q_empty");

endmodule

// File: tb/tb_lru_evict_drain.sv
// Randomized bench for lru_evict_drain against a queue-level reference model.
module tb_lru_evict_drain;

    localparam int unsigned LW = 512;
    localparam int unsigned MW = 64;
    localparam int unsigned AW = 26;
    localparam int unsigned DW = 1 + AW + LW;
    localparam int unsigned NB = LW / MW;
    localparam int unsigned BW = 3;

    typedef struct packed {
        logic [AW+BW-1:0] addr;
        logic [MW-1:0]    data;
        logic             last;
    } beat_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          flush = 1'b0;
    logic          q_empty = 1'b1;
    logic          q_alm_full = 1'b0;
    logic [DW-1:0] q_data = '0;
    logic          mem_req_ready = 1'b0;
    logic          flush_done, q_pop, mem_req_valid, mem_req_last, busy;
    logic [AW+BW-1:0] mem_req_addr;
    logic [MW-1:0]    mem_req_data;
`ifdef LRU_EVICT_PERF_EN
    logic [31:0] perf_dirty_evicts, perf_clean_evicts, perf_stall_cycles;
`endif

    lru_evict_drain dut (
        .clk               (clk),
        .reset             (reset),
        .flush             (flush),
        .flush_done        (flush_done),
        .q_empty           (q_empty),
        .q_alm_full        (q_alm_full),
        .q_data            (q_data),
        .q_pop             (q_pop),
        .mem_req_valid     (mem_req_valid),
        .mem_req_ready     (mem_req_ready),
        .mem_req_addr      (mem_req_addr),
        .mem_req_data      (mem_req_data),
        .mem_req_last      (mem_req_last),
`ifdef LRU_EVICT_PERF_EN
        .perf_dirty_evicts (perf_dirty_evicts),
        .perf_clean_evicts (perf_clean_evicts),
        .perf_stall_cycles (perf_stall_cycles),
`endif
        .busy              (busy)
    );

    always #5 clk = ~clk;

    // Reference model: the victim queue, pending beats of the line in flight, flush flag
    logic [DW-1:0] tbq[$];
    beat_t         exp_beats[$];
    bit            m_fa;
    int            m_dirty, m_clean, m_stall;
    int            n_acc, n_pop;
    int            n_checks, n_fail;

    bit    e_pop, e_valid, e_done, e_busy;
    beat_t e_beat;
    bit    s_pop, s_valid, s_done, s_busy;
    beat_t s_beat;

    function automatic void drive_q();
        q_empty = (tbq.size() == 0);
        q_data  = (tbq.size() != 0) ? tbq[0] : '0;
    endfunction

    function automatic logic [DW-1:0] mk(input bit dirty, input logic [AW-1:0] addr);
        logic [LW-1:0] ln;
        for (int k = 0; k < LW / 32; k++) ln[k*32 +: 32] = $urandom;
        return {dirty, addr, ln};
    endfunction

    // Advance one cycle: compute expectations, sample DUT at negedge, update model after posedge
    task automatic step();
        beat_t         b;
        logic [DW-1:0] ent;
        logic [LW-1:0] ln;
        @(negedge clk);
        e_valid = (exp_beats.size() != 0);
        e_pop   = !e_valid && (tbq.size() != 0) && (q_alm_full || m_fa);
        e_done  = m_fa && !e_valid && (tbq.size() == 0);
        e_busy  = e_valid || m_fa;
        e_beat  = e_valid ? exp_beats[0] : '0;
        s_pop   = q_pop;
        s_valid = mem_req_valid;
        s_done  = flush_done;
        s_busy  = busy;
        s_beat  = {mem_req_addr, mem_req_data, mem_req_last};
        @(posedge clk);
        #1;
        if (e_valid && mem_req_ready) begin
            b = exp_beats.pop_front();
            n_acc++;
        end
        if (e_valid && !mem_req_ready) m_stall++;
        if (e_pop) begin
            ent = tbq.pop_front();
            n_pop++;
            if (ent[DW-1]) begin
                m_dirty++;
                ln = ent[LW-1:0];
                for (int i = 0; i < NB; i++) begin
                    b.addr = {ent[LW +: AW], BW'(i)};
                    b.data = MW'(ln >> (i * MW));
                    b.last = (i == NB - 1);
                    exp_beats.push_back(b);
                end
            end else begin
                m_clean++;
            end
        end
        if (!m_fa) m_fa = flush;
        else if (e_done) m_fa = 1'b0;
        flush = 1'b0;
        drive_q();
    endtask

    task automatic test_reset();
        mem_req_ready = 1'b1;
        q_alm_full    = 1'b1;
        tbq.push_back(mk(1'b1, 26'h55));
        drive_q();
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({q_pop, mem_req_valid, flush_done, busy, mem_req_last, mem_req_addr, mem_req_data} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got pop=%b valid=%b done=%b busy=%b last=%b addr=%h want all 0",
                     q_pop, mem_req_valid, flush_done, busy, mem_req_last, mem_req_addr);
        end
        tbq.delete();
        q_alm_full = 1'b0;
        drive_q();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if ({s_pop, s_valid, s_done, s_busy, s_beat} !== {e_pop, e_valid, e_done, e_busy, e_beat}) begin
                n_fail++;
                $display("FAIL reset_idle: got pop/valid/done/busy=%b%b%b%b want %b%b%b%b",
                         s_pop, s_valid, s_done, s_busy, e_pop, e_valid, e_done, e_busy);
            end
        end
    endtask

    task automatic test_dirty_evict();
        int a0 = n_acc, p0 = n_pop, cyc = 0;
        tbq.push_back(mk(1'b1, 26'h123));
        drive_q();
        q_alm_full    = 1'b1;
        mem_req_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            step();
            cyc++;
            n_checks++;
            if ({s_pop, s_valid, s_done, s_busy, s_beat} !== {e_pop, e_valid, e_done, e_busy, e_beat}) begin
                n_fail++;
                $display("FAIL dirty_beat: got pop=%b valid=%b addr=%h last=%b data=%h want pop=%b valid=%b addr=%h last=%b data=%h",
                         s_pop, s_valid, s_beat.addr, s_beat.last, s_beat.data,
                         e_pop, e_valid, e_beat.addr, e_beat.last, e_beat.data);
            end
            if (tbq.size() == 0 && exp_beats.size() == 0) break;
        end
        q_alm_full = 1'b0;
        n_checks++;
        if ((n_acc - a0) != 8 || (n_pop - p0) != 1 || cyc != 9) begin
            n_fail++;
            $display("FAIL dirty_count: got beats=%0d pops=%0d cycles=%0d want 8 1 9", n_acc - a0, n_pop - p0, cyc);
        end
    endtask

    task automatic test_clean_drain();
        int p0 = n_pop;
        for (int i = 0; i < 3; i++) tbq.push_back(mk(1'b0, 26'($urandom)));
        drive_q();
        q_alm_full = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            n_checks++;
            if ({s_pop, s_valid, s_done, s_busy, s_beat} !== {e_pop, e_valid, e_done, e_busy, e_beat}) begin
                n_fail++;
                $display("FAIL clean_model: got pop=%b valid=%b want pop=%b valid=%b", s_pop, s_valid, e_pop, e_valid);
            end
            n_checks++;
            if (s_pop !== (i < 3) || s_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL clean_pop cycle %0d: got pop=%b valid=%b want pop=%b valid=0", i, s_pop, s_valid, i < 3);
            end
        end
        q_alm_full = 1'b0;
        n_checks++;
        if ((n_pop - p0) != 3) begin
            n_fail++;
            $display("FAIL clean_count: got %0d pops want 3", n_pop - p0);
        end
    endtask

    task automatic test_backpressure();
        logic [3:0] pat = 4'b1001;
        int a0 = n_acc, p0 = n_pop;
        tbq.push_back(mk(1'b1, 26'($urandom)));
        tbq.push_back(mk(1'b1, 26'($urandom)));
        drive_q();
        q_alm_full = 1'b1;
        for (int i = 0; i < 80; i++) begin
            mem_req_ready = pat[i % 4];
            step();
            n_checks++;
            if ({s_pop, s_valid, s_done, s_busy, s_beat} !== {e_pop, e_valid, e_done, e_busy, e_beat}) begin
                n_fail++;
                $display("FAIL backpressure: got pop=%b valid=%b addr=%h data=%h want pop=%b valid=%b addr=%h data=%h",
                         s_pop, s_valid, s_beat.addr, s_beat.data, e_pop, e_valid, e_beat.addr, e_beat.data);
            end
            if (tbq.size() == 0 && exp_beats.size() == 0) break;
        end
        q_alm_full = 1'b0;
        n_checks++;
        if ((n_acc - a0) != 16 || (n_pop - p0) != 2) begin
            n_fail++;
            $display("FAIL backpressure_count: got beats=%0d pops=%0d want 16 2", n_acc - a0, n_pop - p0);
        end
    endtask

    task automatic test_flush();
        int a0 = n_acc, p0 = n_pop, dones = 0;
        tbq.push_back(mk(1'b1, 26'($urandom)));
        tbq.push_back(mk(1'b0, 26'($urandom)));
        tbq.push_back(mk(1'b1, 26'($urandom)));
        drive_q();
        q_alm_full = 1'b0;
        flush      = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (i == 10) flush = 1'b1;
            mem_req_ready = ($urandom % 2) == 0;
            step();
            if (s_done) dones++;
            n_checks++;
            if ({s_pop, s_valid, s_done, s_busy, s_beat} !== {e_pop, e_valid, e_done, e_busy, e_beat}) begin
                n_fail++;
                $display("FAIL flush_drain: got pop=%b valid=%b done=%b busy=%b want %b %b %b %b",
                         s_pop, s_valid, s_done, s_busy, e_pop, e_valid, e_done, e_busy);
            end
            if (i > 11 && !m_fa && exp_beats.size() == 0) break;
        end
        n_checks++;
        if (dones != 1 || (n_pop - p0) != 3 || (n_acc - a0) != 16) begin
            n_fail++;
            $display("FAIL flush_count: got dones=%0d pops=%0d beats=%0d want 1 3 16", dones, n_pop - p0, n_acc - a0);
        end
        // Flush into an already empty queue
        dones = 0;
        flush = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            if (s_done) dones++;
            n_checks++;
            if (s_done !== (i == 1) || s_busy !== e_busy) begin
                n_fail++;
                $display("FAIL flush_empty cycle %0d: got done=%b busy=%b want done=%b busy=%b", i, s_done, s_busy, i == 1, e_busy);
            end
        end
    endtask

    task automatic test_reset_mid();
        int a0 = n_acc;
        tbq.push_back(mk(1'b1, 26'($urandom)));
        drive_q();
        q_alm_full    = 1'b1;
        mem_req_ready = 1'b1;
        for (int i = 0; i < 20 && (n_acc - a0) < 3; i++) step();
        q_alm_full = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if (mem_req_valid !== 1'b0 || busy !== 1'b0 || q_pop !== 1'b0 || (n_acc - a0) != 3) begin
            n_fail++;
            $display("FAIL reset_mid: got valid=%b busy=%b pop=%b beats=%0d want 0 0 0 3", mem_req_valid, busy, q_pop, n_acc - a0);
        end
        exp_beats.delete();
        m_fa    = 1'b0;
        m_dirty = 0;
        m_clean = 0;
        m_stall = 0;
        tbq.push_back(mk(1'b0, 26'($urandom)));
        drive_q();
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) q_alm_full = 1'b1;
            step();
            n_checks++;
            if ({s_pop, s_valid, s_done, s_busy, s_beat} !== {e_pop, e_valid, e_done, e_busy, e_beat}
                || s_pop !== (i == 3)) begin
                n_fail++;
                $display("FAIL reset_recover cycle %0d: got pop=%b valid=%b busy=%b want pop=%b valid=%b busy=%b",
                         i, s_pop, s_valid, s_busy, e_pop, e_valid, e_busy);
            end
        end
        q_alm_full = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 500; i++) begin
            if (i < 400 && tbq.size() < 6 && ($urandom % 3) == 0) begin
                tbq.push_back(mk(1'($urandom), 26'($urandom)));
                drive_q();
            end
            q_alm_full    = (i >= 400) || (tbq.size() >= 5) || (($urandom % 4) == 0);
            mem_req_ready = (i >= 400) || (($urandom % 3) != 0);
            flush         = (i < 400) && (($urandom % 40) == 0);
            step();
            n_checks++;
            if ({s_pop, s_valid, s_done, s_busy, s_beat} !== {e_pop, e_valid, e_done, e_busy, e_beat}) begin
                n_fail++;
                $display("FAIL random cycle %0d: got pop=%b valid=%b done=%b busy=%b addr=%h want %b %b %b %b addr=%h",
                         i, s_pop, s_valid, s_done, s_busy, s_beat.addr, e_pop, e_valid, e_done, e_busy, e_beat.addr);
            end
            if (i >= 400 && tbq.size() == 0 && exp_beats.size() == 0 && !m_fa) break;
        end
        q_alm_full = 1'b0;
    endtask

    task automatic test_perf();
`ifdef LRU_EVICT_PERF_EN
        n_checks++;
        if (perf_dirty_evicts !== 32'(m_dirty) || perf_clean_evicts !== 32'(m_clean)
            || perf_stall_cycles !== 32'(m_stall)) begin
            n_fail++;
            $display("FAIL perf_counters: got dirty=%0d clean=%0d stall=%0d want %0d %0d %0d",
                     perf_dirty_evicts, perf_clean_evicts, perf_stall_cycles, m_dirty, m_clean, m_stall);
        end
`endif
    endtask

    initial begin
        drive_q();
        test_reset();
        test_dirty_evict();
        test_clean_drain();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_random();
        test_perf();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
